// File: rtl/prism_unpackinstr_streamer.sv
// Outbound element-to-beat streamer. It reads EPB elements per beat from the
// SP-local element memory, which returns data one cycle after the read. It
// assembles each beat and presents it on a valid/ready interface with a beat
// index and a last flag.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for start; nbeats sampled here only
//  S_READ  | one element read per cycle, EPB cycles per beat
//  S_DRAIN | last element of the beat returns from memory
//  S_SEND  | beat presented, held until the downstream accepts it
//  S_FIN   | one-cycle done pulse
module prism_unpackinstr_streamer #(
    parameter int NTRANSFERS     = 4,
    parameter int TRANSFER_WIDTH = $clog2(NTRANSFERS),
    parameter int BEAT_WIDTH     = 128,
    parameter int ELEM_WIDTH     = 32,
    parameter int EPB            = BEAT_WIDTH / ELEM_WIDTH,
    parameter int NELEMENTS      = NTRANSFERS * EPB,
    parameter int ELEMENT_WIDTH  = $clog2(NELEMENTS)
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [TRANSFER_WIDTH:0]   nbeats,
    output logic                      busy,
    output logic                      done,
    output logic                      elem_re,
    output logic [ELEMENT_WIDTH-1:0]  elem_addr,
    input  logic [ELEM_WIDTH-1:0]     elem_rdata,
    output logic                      beat_valid,
    input  logic                      beat_ready,
    output logic [BEAT_WIDTH-1:0]     beat_data,
    output logic [TRANSFER_WIDTH-1:0] beat_transfer,
    output logic                      beat_last
);

    localparam int EIW = (EPB > 1) ? $clog2(EPB) : 1;
    localparam logic [TRANSFER_WIDTH:0] MAX_BEATS = (TRANSFER_WIDTH + 1)'(NTRANSFERS);
    localparam logic [EIW-1:0] LAST_ELEM = EIW'(EPB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_SEND,
        S_FIN
    } state_t;

    state_t                    state_q, state_d;
    logic [TRANSFER_WIDTH:0]   count_q, count_d;
    logic [TRANSFER_WIDTH-1:0] beat_idx_q, beat_idx_d;
    logic [EIW-1:0]            elem_idx_q, elem_idx_d;
    logic                      rd_vld_q, rd_vld_d;
    logic [EIW-1:0]            rd_idx_q, rd_idx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      elem_re_q, elem_re_d;
    logic [ELEMENT_WIDTH-1:0]  elem_addr_q, elem_addr_d;
    logic                      beat_valid_q, beat_valid_d;
    logic [BEAT_WIDTH-1:0]     beat_data_q, beat_data_d;
    logic [TRANSFER_WIDTH-1:0] beat_transfer_q, beat_transfer_d;
    logic                      beat_last_q, beat_last_d;

    // Next-state, counters, element capture and registered output decode
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        beat_idx_d      = beat_idx_q;
        elem_idx_d      = elem_idx_q;
        beat_data_d     = beat_data_q;
        rd_vld_d        = elem_re_q;
        rd_idx_d        = elem_idx_q;

        // Read data lands one cycle after the request; the delayed index
        // picks its slot in the beat.
        if (rd_vld_q) begin
            beat_data_d[rd_idx_q*ELEM_WIDTH +: ELEM_WIDTH] = elem_rdata;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (nbeats == '0) begin
                        state_d = S_FIN;
                    end else begin
                        count_d    = (nbeats > MAX_BEATS) ? MAX_BEATS : nbeats;
                        beat_idx_d = '0;
                        elem_idx_d = '0;
                        state_d    = S_READ;
                    end
                end
            end
            S_READ: begin
                if (elem_idx_q == LAST_ELEM) begin
                    elem_idx_d = '0;
                    state_d    = S_DRAIN;
                end else begin
                    elem_idx_d = elem_idx_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_SEND;
            end
            S_SEND: begin
                if (beat_valid_q && beat_ready) begin
                    if (beat_last_q) begin
                        state_d = S_FIN;
                    end else begin
                        beat_idx_d = beat_idx_q + 1'b1;
                        elem_idx_d = '0;
                        state_d    = S_READ;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d          = (state_d != S_IDLE);
        done_d          = (state_d == S_FIN);
        elem_re_d       = (state_d == S_READ);
        beat_valid_d    = (state_d == S_SEND);
        elem_addr_d     = '0;
        beat_transfer_d = '0;
        beat_last_d     = 1'b0;
        if (state_d == S_READ) begin
            elem_addr_d = ELEMENT_WIDTH'(beat_idx_d) * ELEMENT_WIDTH'(EPB)
                        + ELEMENT_WIDTH'(elem_idx_d);
        end
        if (state_d == S_SEND) begin
            beat_transfer_d = beat_idx_d;
            beat_last_d     = ({1'b0, beat_idx_d} == (count_d - 1'b1));
        end
    end

    // State and output registers; reset abandons any command in flight
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            count_q         <= '0;
            beat_idx_q      <= '0;
            elem_idx_q      <= '0;
            rd_vld_q        <= 1'b0;
            rd_idx_q        <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            elem_re_q       <= 1'b0;
            elem_addr_q     <= '0;
            beat_valid_q    <= 1'b0;
            beat_data_q     <= '0;
            beat_transfer_q <= '0;
            beat_last_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            beat_idx_q      <= beat_idx_d;
            elem_idx_q      <= elem_idx_d;
            rd_vld_q        <= rd_vld_d;
            rd_idx_q        <= rd_idx_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            elem_re_q       <= elem_re_d;
            elem_addr_q     <= elem_addr_d;
            beat_valid_q    <= beat_valid_d;
            beat_data_q     <= beat_data_d;
            beat_transfer_q <= beat_transfer_d;
            beat_last_q     <= beat_last_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign elem_re       = elem_re_q;
    assign elem_addr     = elem_addr_q;
    assign beat_valid    = beat_valid_q;
    assign beat_data     = beat_data_q;
    assign beat_transfer = beat_transfer_q;
    assign beat_last     = beat_last_q;

endmodule

// File: tb/tb_prism_unpackinstr_streamer.sv
// Bench for prism_unpackinstr_streamer: a behavioural element memory, a
// ready generator with optional backpressure and a scoreboard of expected
// addresses and beats filled when each command is issued.
module tb_prism_unpackinstr_streamer;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   nbeats = '0;
    logic         busy, done, elem_re, beat_valid, beat_last;
    logic [3:0]   elem_addr;
    logic [31:0]  elem_rdata = '0;
    logic         beat_ready = 1'b0;
    logic [127:0] beat_data;
    logic [1:0]   beat_transfer;

    int checks = 0;
    int errors = 0;

    logic [31:0]  mem [16];
    logic [3:0]   exp_addr_q [$];
    logic [130:0] exp_beat_q [$];

    int  done_cnt = 0;
    int  beat_cnt = 0;
    int  re_cnt = 0;
    int  valid_cnt = 0;
    bit  bp_mode = 1'b0;
    int  wait_cnt = 0;
    bit  prev_stall = 1'b0;
    logic [130:0] prev_vec = '0;

    prism_unpackinstr_streamer dut (
        .clock         (clock),
        .resetn        (resetn),
        .start         (start),
        .nbeats        (nbeats),
        .busy          (busy),
        .done          (done),
        .elem_re       (elem_re),
        .elem_addr     (elem_addr),
        .elem_rdata    (elem_rdata),
        .beat_valid    (beat_valid),
        .beat_ready    (beat_ready),
        .beat_data     (beat_data),
        .beat_transfer (beat_transfer),
        .beat_last     (beat_last)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [131:0] got, input logic [131:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One-cycle-latency element memory
    always @(posedge clock) begin
        if (elem_re) elem_rdata <= mem[elem_addr];
    end

    // Ready generator: always ready, or ready only after 3 stalled cycles
    always @(posedge clock) begin
        #1;
        if (!resetn) begin
            wait_cnt   = 0;
            beat_ready = 1'b0;
        end else if (!bp_mode) begin
            beat_ready = 1'b1;
        end else if (!beat_valid) begin
            beat_ready = 1'b0;
            wait_cnt   = 0;
        end else if (wait_cnt < 3) begin
            beat_ready = 1'b0;
            wait_cnt++;
        end else begin
            beat_ready = 1'b1;
            wait_cnt   = 0;
        end
    end

    // Monitor: address and beat scoreboard, stall stability, event counts
    always @(negedge clock) begin
        logic [130:0] vec;
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (elem_re) begin
                re_cnt++;
                if (exp_addr_q.size() == 0) check_val("addr_extra", 1, 0);
                else check_val("elem_addr", elem_addr, exp_addr_q.pop_front());
            end
            if (beat_valid) begin
                valid_cnt++;
                vec = {beat_data, beat_transfer, beat_last};
                if (prev_stall) check_val("stall_hold", vec, prev_vec);
                prev_stall = !beat_ready;
                prev_vec   = vec;
                if (beat_ready) begin
                    beat_cnt++;
                    if (exp_beat_q.size() == 0) check_val("beat_extra", 1, 0);
                    else check_val("beat", vec, exp_beat_q.pop_front());
                end
            end else begin
                prev_stall = 1'b0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic pulse_start(input int nb);
        start  = 1'b1;
        nbeats = 3'(nb);
        @(posedge clock) #1;
        start  = 1'b0;
        nbeats = '0;
    endtask

    task automatic cmd(input int nb);
        int n;
        logic [127:0] d;
        n = (nb > 4) ? 4 : nb;
        for (int b = 0; b < n; b++) begin
            for (int e = 0; e < 4; e++) begin
                exp_addr_q.push_back(4'(b*4 + e));
                d[e*32 +: 32] = mem[b*4 + e];
            end
            exp_beat_q.push_back({d, 2'(b), (b == n-1)});
        end
        pulse_start(nb);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_val("done_timeout", seen, 1);
        @(posedge clock) #1;
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (beat_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_val("valid_timeout", seen, 1);
    endtask

    task automatic timed(input int nb, input int len, output int f_re, output int l_re,
                         output int f_v, output int f_d, output logic [127:0] d_v,
                         output logic [3:0] a_first);
        f_re = -1; l_re = -1; f_v = -1; f_d = -1; d_v = '0; a_first = '0;
        cmd(nb);
        for (int k = 1; k <= len; k++) begin
            @(negedge clock);
            if (elem_re && f_re < 0) begin
                f_re    = k;
                a_first = elem_addr;
            end
            if (elem_re) l_re = k;
            if (beat_valid && f_v < 0) begin
                f_v = k;
                d_v = beat_data;
            end
            if (done && f_d < 0) f_d = k;
            @(posedge clock) #1;
        end
    endtask

    initial begin
        int f_re, l_re, f_v, f_d, b0, d0;
        logic [127:0] d_v;
        logic [3:0]   a_first;

        for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;

        #12;
        check_val("reset_outputs",
                  {busy, done, elem_re, elem_addr, beat_valid, beat_data, beat_transfer, beat_last}, 0);
        resetn = 1'b1;
        @(posedge clock) #1;

        // Reset while a beat is being presented
        bp_mode = 1'b1;
        cmd(2);
        wait_valid();
        d0 = done_cnt;
        #2 resetn = 1'b0;
        #1;
        check_val("async_reset_outputs",
                  {busy, done, elem_re, elem_addr, beat_valid, beat_data, beat_transfer, beat_last}, 0);
        exp_addr_q.delete();
        exp_beat_q.delete();
        repeat (3) @(posedge clock);
        check_val("no_done_on_reset", done_cnt, d0);
        #2 resetn = 1'b1;
        bp_mode = 1'b0;
        @(posedge clock) #1;

        // Single beat, timing and content
        timed(1, 10, f_re, l_re, f_v, f_d, d_v, a_first);
        check_val("single_first_re", f_re, 1);
        check_val("single_last_re", l_re, 4);
        check_val("single_valid_cycle", f_v, 6);
        check_val("single_done_cycle", f_d, 7);
        check_val("single_data", d_v, 128'h00000103_00000102_00000101_00000100);

        // Full command with backpressure
        bp_mode = 1'b1;
        b0 = beat_cnt; d0 = done_cnt;
        cmd(4);
        wait_done();
        repeat (3) @(posedge clock);
        #1;
        check_val("bp_beats", beat_cnt - b0, 4);
        check_val("bp_done_count", done_cnt - d0, 1);
        bp_mode = 1'b0;

        // Zero beats
        b0 = re_cnt; d0 = valid_cnt;
        timed(0, 4, f_re, l_re, f_v, f_d, d_v, a_first);
        check_val("zero_done_cycle", f_d, 1);
        check_val("zero_no_re", re_cnt - b0, 0);
        check_val("zero_no_valid", valid_cnt - d0, 0);

        // Clamp
        b0 = beat_cnt;
        cmd(7);
        wait_done();
        check_val("clamp_beats", beat_cnt - b0, 4);

        // Start pulses while busy are ignored
        bp_mode = 1'b1;
        b0 = beat_cnt;
        cmd(2);
        pulse_start(4);
        wait_valid();
        @(posedge clock) #1;
        pulse_start(1);
        wait_done();
        repeat (2) @(posedge clock);
        #1;
        check_val("busy_start_beats", beat_cnt - b0, 2);
        bp_mode = 1'b0;

        // Back-to-back commands
        cmd(1);
        wait_done();
        timed(2, 16, f_re, l_re, f_v, f_d, d_v, a_first);
        check_val("b2b_first_re", f_re, 1);
        check_val("b2b_first_addr", a_first, 0);
        check_val("b2b_last_re", l_re, 10);
        check_val("b2b_valid_cycle", f_v, 6);
        check_val("b2b_done_cycle", f_d, 13);

        check_val("addr_queue_empty", exp_addr_q.size(), 0);
        check_val("beat_queue_empty", exp_beat_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prism_unpackinstr_streamer.md
Name: prism_unpackinstr_streamer

Overview:
- Outbound counterpart of the pack-instruction path: reads elements from the SP-local element memory and assembles them into AXI-width beats for the outbound AXI write data channel.
- Driven by a start/nbeats command from the SP sequencer.
- Issues one element read per cycle to a 1-cycle-latency memory port.
- Presents each assembled beat with a valid/ready handshake, beat index and last flag.

Parameters:
- NTRANSFERS, 4, max AXI beats per command.
- TRANSFER_WIDTH, $clog2(NTRANSFERS), beat index width.
- BEAT_WIDTH, 128, AXI data width.
- ELEM_WIDTH, 32, element data width; BEAT_WIDTH must be a multiple of ELEM_WIDTH.
- EPB, BEAT_WIDTH/ELEM_WIDTH, elements per beat (derived).
- NELEMENTS, NTRANSFERS*EPB, element memory depth.
- ELEMENT_WIDTH, $clog2(NELEMENTS), element address width.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  command strobe, sampled only in IDLE
- nbeats  in  TRANSFER_WIDTH+1  beats to emit (0..NTRANSFERS)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at command completion
- elem_re  out  1  element memory read enable
- elem_addr  out  ELEMENT_WIDTH  element memory read address
- elem_rdata  in  ELEM_WIDTH  read data, valid the cycle after elem_re
- beat_valid  out  1  beat_data valid
- beat_ready  in  1  downstream accept
- beat_data  out  BEAT_WIDTH  assembled beat
- beat_transfer  out  TRANSFER_WIDTH  index of the presented beat
- beat_last  out  1  presented beat is the final beat of the command

Behaviour:
- Reset: every output is 0; FSM state is IDLE; all counters are 0. Assertion of resetn mid-command discards the command immediately; no done pulse is generated.
- States: IDLE, READ, DRAIN, SEND, FIN.
- IDLE:
  - start=1 and nbeats=0 -> FIN.
  - start=1 and nbeats>0 -> latch min(nbeats, NTRANSFERS) as the beat count; beat_index=0, elem_index=0; go to READ.
  - start is ignored outside IDLE.
- READ (EPB cycles per beat):
  - elem_re=1, elem_addr=beat_index*EPB+elem_index, elem_index increments each cycle.
  - On elem_index==EPB-1 -> DRAIN.
  - Capture: elem_rdata returned for element j is written to beat_data[j*ELEM_WIDTH +: ELEM_WIDTH], using a delayed copy of elem_index.
- DRAIN (1 cycle): captures the final element -> SEND.
- SEND:
  - beat_valid=1; beat_transfer=beat_index; beat_last=(beat_index==count-1).
  - beat_data, beat_transfer and beat_last are held stable while beat_valid=1 and beat_ready=0.
  - On beat_valid&&beat_ready: if beat_last -> FIN, else beat_index++, elem_index=0 -> READ.
  - beat_valid drops the cycle after acceptance.
- FIN: done=1 for exactly one cycle -> IDLE.
- busy=1 in READ, DRAIN, SEND and FIN.
- Latency:
  - start accepted at edge E0; elem_re high on cycles 1..EPB; beat_valid rises at cycle EPB+2.
  - With beat_ready held at 1, each beat occupies EPB+2 cycles.
  - done pulses the cycle after the last handshake.
- No read is issued while in SEND (no prefetch); elem_re=0 outside READ.
- Element addresses never exceed count*EPB-1; no wrap-around.

Test Plan:
- Reset mid-operation:
  - Stimulus: resetn low during SEND.
  - Required: all outputs 0 asynchronously; no done pulse.
  - Then start nbeats=1 -> normal operation: beat_valid at cycle 6, single beat, done at cycle 7.
- Single beat:
  - Stimulus: memory mem[i]=i+0x100, start nbeats=1, beat_ready=1.
  - Required: elem_addr 0,1,2,3 on cycles 1-4; beat_valid at cycle 6 with beat_data=0x00000103_00000102_00000101_00000100, beat_transfer=0, beat_last=1; done at cycle 7.
- Full command with backpressure:
  - Stimulus: nbeats=4; beat_ready low for 3 cycles on each beat.
  - Required: 4 beats with beat_transfer 0..3 and data words 0x100..0x10F in order; beat_data stable while stalled; beat_last only on beat 3; exactly one done.
- Zero and clamp:
  - nbeats=0 -> done on cycle 1, elem_re never high, beat_valid never high.
  - nbeats=7 -> exactly 4 beats emitted.
- Start while busy: second start pulse during READ and during SEND -> ignored; beat count and addresses unchanged.
- Back-to-back commands: start asserted in the cycle immediately after done (nbeats=2) -> accepted; elem_addr restarts at 0.
